// File: rtl/disp_scan_ctrl_pkg.sv
// disp_pkg: shared widths, scan FSM state type and PWM limit helper
package disp_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int SEL_W = 3;
  localparam int BRIGHT_W = 2;
  typedef enum logic {OFF, SCAN} scan_state_t;
  function automatic int on_lim(int td, int g, int k);
    return g + ((td - g) * (k + 1)) / 4;
  endfunction
endpackage

// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if: control inputs, display drive and update handshake of the scan controller
interface disp_scan_ctrl_if;
  import disp_pkg::*;
  logic                  enable;
  logic [NUM_DIGITS-1:0] digit_en;
  logic [BRIGHT_W-1:0]   bright;
  logic                  upd_req;
  logic [SEL_W-1:0]      sel;
  logic [NUM_DIGITS-1:0] an;
  logic                  frame_done;
  logic                  upd_ack;
  modport master (output enable, digit_en, bright, upd_req, input sel, an, frame_done, upd_ack);
  modport slave (input enable, digit_en, bright, upd_req, output sel, an, frame_done, upd_ack);
endinterface

// File: rtl/disp_scan_ctrl_slot_timer.sv
// disp_slot_timer: tick counter within a digit slot and slot counter across a frame
module disp_slot_timer
  import disp_pkg::*;
#(
  parameter int TICK_DIV = 100_000,
  localparam int TW = $clog2(TICK_DIV)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run_i,
  output logic [SEL_W-1:0] slot_o,
  output logic [TW-1:0]    tick_o,
  output logic             slot_start_o,
  output logic             frame_end_o
);
  logic [TW-1:0]    tick_q, tick_d;
  logic [SEL_W-1:0] slot_q, slot_d;
  logic             last;
  assign last = tick_q == TW'(TICK_DIV - 1);
  always_comb begin
    tick_d = (!run_i || last) ? '0 : tick_q + 1'b1;
    slot_d = !run_i ? '0 : last ? slot_q + 1'b1 : slot_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tick_q <= '0;
      slot_q <= '0;
    end else begin
      tick_q <= tick_d;
      slot_q <= slot_d;
    end
  assign slot_o       = slot_q;
  assign tick_o       = tick_q;
  assign slot_start_o = tick_q == '0;
  assign frame_end_o  = last && slot_q == SEL_W'(NUM_DIGITS - 1);
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 8-digit display scan with anti-ghost guard, brightness PWM and frame-aligned update ack
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int TICK_DIV = 100_000,
  parameter int GUARD    = 64
) (
  input logic             clk,
  input logic             reset_n,
  disp_scan_ctrl_if.slave bus
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = TW + 1;
  localparam logic [CW-1:0] ON_LIM [4] = '{CW'(on_lim(TICK_DIV, GUARD, 0)), CW'(on_lim(TICK_DIV, GUARD, 1)),
                                           CW'(on_lim(TICK_DIV, GUARD, 2)), CW'(on_lim(TICK_DIV, GUARD, 3))};
  scan_state_t           state_q, state_d;
  logic                  run, slot_start, frame_end, lit;
  logic [SEL_W-1:0]      slot;
  logic [TW-1:0]         tick;
  logic [NUM_DIGITS-1:0] en_l_q, en_eff;
  logic [BRIGHT_W-1:0]   br_l_q, br_eff;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q, fd_d, ack_q, ack_d, ackd_q, ackd_d;
  assign run = state_q == SCAN && bus.enable;
  disp_slot_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk(clk), .reset_n(reset_n), .run_i(run), .slot_o(slot), .tick_o(tick),
    .slot_start_o(slot_start), .frame_end_o(frame_end)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= OFF;
    else state_q <= state_d;
  always_comb state_d = bus.enable ? SCAN : OFF;
  // Shadows load at every slot start; use live inputs on that first tick so the slot sees them.
  assign en_eff = slot_start ? bus.digit_en : en_l_q;
  assign br_eff = slot_start ? bus.bright : br_l_q;
  assign lit    = run && en_eff[slot] && {1'b0, tick} >= CW'(GUARD) && {1'b0, tick} < ON_LIM[br_eff];
  // ackd_q holds off a repeat ack until the requester has dropped upd_req.
  always_comb begin
    sel_d  = run ? slot : '0;
    an_d   = lit ? ~(NUM_DIGITS'(1) << slot) : '1;
    fd_d   = run && frame_end;
    ack_d  = bus.upd_req && !ackd_q && (state_q == OFF ? 1'b1 : run && frame_end);
    ackd_d = bus.upd_req && (ackd_q || ack_d);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      en_l_q <= '0;
      br_l_q <= '0;
      sel_q  <= '0;
      an_q   <= '1;
      fd_q   <= 1'b0;
      ack_q  <= 1'b0;
      ackd_q <= 1'b0;
    end else begin
      if (run && slot_start) begin
        en_l_q <= bus.digit_en;
        br_l_q <= bus.bright;
      end
      sel_q  <= sel_d;
      an_q   <= an_d;
      fd_q   <= fd_d;
      ack_q  <= ack_d;
      ackd_q <= ackd_d;
    end
  assign bus.sel        = sel_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;
  assign bus.upd_ack    = ack_q;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed scan/PWM/handshake sequence checked against a frame-position model via a scoreboard
module tb_disp_scan_ctrl;
  import disp_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  disp_scan_ctrl_if bus();
  disp_scan_ctrl #(.TICK_DIV(16), .GUARD(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [12:0] RST_VEC = {3'd0, 8'hFF, 1'b0, 1'b0};
  int tests = 0;
  int fails = 0;
  string tag;
  logic [12:0] sb[$];
  bit m_scan, m_done, m_ack;
  int m_pos;
  logic [7:0] m_en;
  logic [1:0] m_br;
  int lim[4] = '{5, 9, 12, 16};
  task automatic model_reset();
    m_scan = 0;
    m_pos = 0;
    m_done = 0;
    m_ack = 0;
    sb.delete();
  endtask
  // Expected outputs after the coming edge, as {sel, an, frame_done, upd_ack}.
  task automatic predict();
    logic [2:0] s;
    logic [7:0] an;
    logic fd, ack;
    int t;
    s = 3'd0;
    an = 8'hFF;
    fd = 1'b0;
    ack = 1'b0;
    if (m_scan && bus.enable) begin
      s = 3'(m_pos / 16);
      t = m_pos % 16;
      if (t == 0) begin
        m_en = bus.digit_en;
        m_br = bus.bright;
      end
      if (m_en[s] && t >= 2 && t < lim[m_br]) an[s] = 1'b0;
      fd = m_pos == 127;
      ack = fd && bus.upd_req && !m_done;
      m_pos = (m_pos + 1) % 128;
    end else begin
      ack = !m_scan && bus.upd_req && !m_done;
      m_pos = 0;
    end
    m_done = bus.upd_req && (m_done || ack);
    m_scan = bus.enable;
    m_ack = ack;
    sb.push_back({s, an, fd, ack});
  endtask
  task automatic check();
    logic [12:0] e, g;
    e = sb.pop_front();
    g = {bus.sel, bus.an, bus.frame_done, bus.upd_ack};
    tests++;
    assert (g === e) else begin
      fails++;
      $error("FAIL %s: got sel/an/fd/ack=%h expected %h", tag, g, e);
    end
  endtask
  task automatic cyc(int n = 1);
    repeat (n) begin
      predict();
      @(posedge clk);
      #1;
      check();
    end
  endtask
  task automatic until_pos(int p);
    for (int i = 0; i < 300 && m_pos != p; i++) cyc();
    tests++;
    if (m_pos != p) begin
      fails++;
      $error("FAIL %s: position wait expired at %0d expected %0d", tag, m_pos, p);
    end
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.digit_en = 8'hFF;
    bus.bright = 2'd3;
    bus.upd_req = 1'b0;
    model_reset();
    #1 reset_n = 1'b0;
    #1 tag = "reset";
    sb.push_back(RST_VEC);
    check();
    @(posedge clk);
    #1 reset_n = 1'b1;
    tag = "idle";
    cyc(3);
    tag = "full_frame";
    bus.enable = 1'b1;
    cyc(148);
    tag = "dim";
    until_pos(32);
    bus.bright = 2'd0;
    cyc(8);
    bus.bright = 2'd2;
    cyc(24);
    tag = "mask";
    bus.digit_en = 8'hF0;
    bus.bright = 2'd3;
    until_pos(0);
    cyc(128);
    tag = "ack_scan";
    bus.digit_en = 8'hFF;
    until_pos(48);
    bus.upd_req = 1'b1;
    for (int i = 0; i < 200 && !m_ack; i++) cyc();
    bus.upd_req = 1'b0;
    cyc(3);
    tag = "ack_off";
    bus.enable = 1'b0;
    cyc(2);
    bus.upd_req = 1'b1;
    cyc(1);
    cyc(3);
    bus.upd_req = 1'b0;
    cyc(1);
    bus.upd_req = 1'b1;
    cyc(1);
    bus.upd_req = 1'b0;
    cyc(2);
    tag = "race";
    bus.enable = 1'b1;
    until_pos(127);
    bus.enable = 1'b0;
    bus.upd_req = 1'b1;
    cyc(2);
    bus.upd_req = 1'b0;
    cyc(2);
    tag = "stop";
    bus.enable = 1'b1;
    until_pos(87);
    bus.enable = 1'b0;
    cyc(3);
    bus.enable = 1'b1;
    cyc(20);
    tag = "rst_mid";
    bus.upd_req = 1'b1;
    #2 reset_n = 1'b0;
    #1 model_reset();
    sb.push_back(RST_VEC);
    check();
    @(posedge clk);
    #1 sb.push_back(RST_VEC);
    check();
    reset_n = 1'b1;
    cyc(1);
    bus.upd_req = 1'b0;
    cyc(20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
